// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with per-frame data width, parity and stop
// length, clocked by clk with s_tick as the oversampling clock enable.
// Also drives a line break (tx held low) on request while idle.
module uart_tx_cfg #(
  parameter int DBIT_MAX = 8,
  parameter int OS       = 16,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_tick,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [DBIT_MAX-1:0] tx_data,
  input  logic [1:0]          data_bits,
  input  logic [1:0]          parity_mode,
  input  logic [1:0]          stop_sel,
  input  logic                break_req,
  output logic                tx,
  output logic                tx_done_tick,
  output logic                busy
);

  // S_BREAK keeps the line low while break_req is held; leaving it always
  // passes through S_IDLE, so a pending frame's start bit is preceded by at
  // least one clk of mark and the receiver sees a clean falling edge.
  typedef enum logic [2:0] {
    S_IDLE,
    S_BREAK,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [CNT_W-1:0] LIM_BIT    = CNT_W'(OS - 1);
  localparam logic [CNT_W-1:0] LIM_STOP15 = CNT_W'((3 * OS) / 2 - 1);
  localparam logic [CNT_W-1:0] LIM_STOP2  = CNT_W'(2 * OS - 1);
  localparam logic [3:0]       DMAX       = 4'(DBIT_MAX);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    tick_q, tick_d;
  logic [3:0]          bit_q, bit_d;
  logic [3:0]          nbits_q, nbits_d;
  logic [DBIT_MAX-1:0] shift_q, shift_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d;
  logic [1:0]          stop_q, stop_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;

  logic                accept;
  logic [3:0]          nbits_in;
  logic                par_in;
  logic [CNT_W-1:0]    stop_lim;

  assign tx_ready     = (state_q == S_IDLE) && !break_req;
  assign accept       = tx_valid && tx_ready;
  assign busy         = (state_q != S_IDLE) && (state_q != S_BREAK);
  assign tx           = tx_q;
  assign tx_done_tick = done_q;

  // Decode the offered character's width and parity bit ahead of latching
  always_comb begin
    nbits_in = 4'd5 + {2'b00, data_bits};
    if (nbits_in > DMAX) begin
      nbits_in = DMAX;
    end
    par_in = (parity_mode == 2'b10);
    for (int i = 0; i < DBIT_MAX; i++) begin
      if (i < int'(nbits_in)) begin
        par_in = par_in ^ tx_data[i];
      end
    end
  end

  // Stop-bit length in ticks from the shadowed stop selection
  always_comb begin
    case (stop_q)
      2'b00:   stop_lim = LIM_BIT;
      2'b01:   stop_lim = LIM_STOP15;
      default: stop_lim = LIM_STOP2;
    endcase
  end

  // Next-state, tick/bit counting and the registered line value
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    nbits_d   = nbits_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop_d    = stop_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (break_req) begin
          state_d = S_BREAK;
        end else if (accept) begin
          state_d   = S_START;
          tick_d    = '0;
          bit_d     = '0;
          shift_d   = tx_data;
          nbits_d   = nbits_in;
          par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          par_bit_d = par_in;
          stop_d    = stop_sel;
        end
      end
      S_BREAK: begin
        if (!break_req) begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (s_tick) begin
          if (tick_q == LIM_BIT) begin
            tick_d  = '0;
            state_d = S_DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (s_tick) begin
          if (tick_q == LIM_BIT) begin
            tick_d = '0;
            if (bit_q == nbits_q - 4'd1) begin
              state_d = par_en_q ? S_PARITY : S_STOP;
            end else begin
              bit_d   = bit_q + 4'd1;
              shift_d = {1'b0, shift_q[DBIT_MAX-1:1]};
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (s_tick) begin
          if (tick_q == LIM_BIT) begin
            tick_d  = '0;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (s_tick) begin
          if (tick_q == stop_lim) begin
            tick_d  = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_BREAK:  tx_d = 1'b0;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      nbits_q   <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop_q    <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      nbits_q   <= nbits_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop_q    <= stop_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule
